// File: rtl/cfglut6_loader.sv
// cfglut6_loader: run-time reconfigurable 6-input LUT with a serial config writer.
// A 64-bit truth table is accepted over a valid/ready handshake and shifted
// MSB first into the config shift register, SHIFT_WIDTH bits per clock. The
// top SHIFT_WIDTH bits of that register leave on CDO for daisy-chaining.
// Optional feature macro: CFGLUT_SHADOW_EN. When defined, O evaluates from a
// shadow register that is updated atomically at COMMIT. When undefined, O
// evaluates from the live shift register, as CFGLUT hardware does.
module cfglut6_loader #(
  parameter logic [63:0] INIT        = 64'h0000000000000000,
  parameter int          SHIFT_WIDTH = 1
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   I0,
  input  logic                   I1,
  input  logic                   I2,
  input  logic                   I3,
  input  logic                   I4,
  input  logic                   I5,
  output logic                   O,
  input  logic                   CFG_VALID,
  output logic                   CFG_READY,
  input  logic [63:0]            CFG_DATA,
  output logic                   CFG_BUSY,
  output logic                   CFG_DONE,
  output logic [SHIFT_WIDTH-1:0] CDO
);

  localparam int W     = SHIFT_WIDTH;
  localparam int N     = 64 / W;
  localparam int CNT_W = $clog2(N);

  // Reject unsupported shift widths while the design elaborates.
  if (!(W == 1 || W == 2 || W == 4 || W == 8)) begin : g_bad_width
    $error("cfglut6_loader: SHIFT_WIDTH must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [63:0]      lb;         // load buffer, drained MSB first
  logic [63:0]      csr;        // config shift register
  logic [63:0]      eval_cfg;   // table that O evaluates
  logic [CNT_W-1:0] cnt;        // groups shifted so far in this load
  logic [5:0]       idx;
  logic             accept;
  logic             last_shift;

  assign accept     = CFG_VALID && (state == IDLE);
  assign last_shift = (cnt == CNT_W'(N - 1));

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      // NOTE: state elements use non-blocking assignment so every flop samples
      // pre-edge values, regardless of the order in which blocks evaluate.
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> SHIFT on handshake, N shifts, one COMMIT cycle.
  always_comb begin
    // NOTE: the default assignment comes first, so no path through the case
    // leaves state_next unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (accept)     state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = COMMIT;
      COMMIT:                  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Load buffer, group counter and config shift register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: the whole config register is reset to INIT. This is a flop bank,
      // not a RAM, so an asynchronous reset value is cheap and it makes an
      // aborted load revert O immediately.
      lb  <= '0;
      cnt <= '0;
      csr <= INIT;
    end else if (accept) begin
      lb  <= CFG_DATA;
      cnt <= '0;
    end else if (state == SHIFT) begin
      csr <= {csr[63-W:0], lb[63 -: W]};
      lb  <= lb << W;
      cnt <= cnt + 1'b1;
    end
  end

  // One-cycle completion pulse, high in the cycle after the COMMIT edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CFG_DONE <= 1'b0;
    end else begin
      CFG_DONE <= (state == COMMIT);
    end
  end

`ifdef CFGLUT_SHADOW_EN
  logic [63:0] act;

  // Shadow table: the fully shifted table becomes visible only at COMMIT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      act <= INIT;
    end else if (state == COMMIT) begin
      act <= csr;
    end
  end

  assign eval_cfg = act;
`else
  assign eval_cfg = csr;
`endif

  assign idx       = {I5, I4, I3, I2, I1, I0};
  assign O         = eval_cfg[idx];
  assign CFG_READY = (state == IDLE);
  assign CFG_BUSY  = (state == SHIFT) || (state == COMMIT);
  assign CDO       = csr[63 -: W];

endmodule
